// File: rtl/mux_scan_capture_pkg.sv
// Shared definitions for the five-input scan capture controller.
//   S_IDLE/S_SETTLE/S_SAMPLE/S_DONE : 2-bit FSM state encodings
//   SEL_LAST                        : highest legal mux select value
//   NUM_INPUTS                      : number of mux inputs gathered per capture
package mux_scan_capture_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE   = 2'd0;
  localparam state_t S_SETTLE = 2'd1;
  localparam state_t S_SAMPLE = 2'd2;
  localparam state_t S_DONE   = 2'd3;

  localparam logic [2:0]  SEL_LAST   = 3'd4;
  localparam int unsigned NUM_INPUTS = 5;

endpackage

// File: rtl/mux_scan_capture_if.sv
// Control/result bundle between a requester and mux_scan_capture.
//   start    : request one capture (requester -> capture block)
//   abort    : cancel an in-progress capture (requester -> capture block)
//   busy     : capture in progress (capture block -> requester)
//   done     : one-cycle completion pulse (capture block -> requester)
//   data_out : captured word, bit 4 = select 0 ... bit 0 = select 4
interface mux_scan_capture_if;
  logic       start;
  logic       abort;
  logic       busy;
  logic       done;
  logic [4:0] data_out;

  modport master (output start, output abort, input  busy, input  done, input  data_out);
  modport slave  (input  start, input  abort, output busy, output done, output data_out);
endinterface

// File: rtl/five_to_one_mux_using_case.sv
// Five-input single-bit select mux.
//   a..e : data inputs selected by s = 0..4
//   s    : 3-bit select; values 5..7 give 0
//   f    : selected bit
module five_to_one_mux_using_case (
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       d,
  input  logic       e,
  input  logic [2:0] s,
  output logic       f
);
  always_comb begin
    f = 1'b0;
    case (s)
      3'd0:    f = a;
      3'd1:    f = b;
      3'd2:    f = c;
      3'd3:    f = d;
      3'd4:    f = e;
      default: f = 1'b0;
    endcase
  end
endmodule

// File: rtl/mux_scan_capture.sv
// Steps a 5:1 mux select through 0..4, waits SETTLE_CYCLES after each
// select change, samples the mux output and assembles a 5-bit word.
//   clk, rst_n : clock, asynchronous active-low reset
//   f_in       : mux output bit
//   sel        : registered mux select, always 0..4
//   cap        : start/abort in, busy/done/data_out out (slave side)
module mux_scan_capture
  import mux_scan_capture_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned CNT_W         = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mux_scan_capture_if.slave    cap,
  input  logic                 f_in,
  output logic [2:0]           sel
);

  // With zero settle time the counter is never consulted; SAMPLE is entered directly.
  localparam logic [CNT_W-1:0] CNT_RELOAD =
    (SETTLE_CYCLES == 0) ? '0 : CNT_W'(SETTLE_CYCLES - 1);
  localparam state_t FIRST_STEP = (SETTLE_CYCLES == 0) ? S_SAMPLE : S_SETTLE;

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [2:0]              sel_q;
  logic [NUM_INPUTS-1:0]   shift_q;
  logic [NUM_INPUTS-1:0]   data_q;
  logic                    busy_q;
  logic                    done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      sel_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          sel_q <= '0;
          if (cap.start && !cap.abort) begin
            cnt     <= CNT_RELOAD;
            shift_q <= '0;
            busy_q  <= 1'b1;
            state   <= FIRST_STEP;
          end
        end

        S_SETTLE: begin
          if (cap.abort) begin
            sel_q   <= '0;
            shift_q <= '0;
            busy_q  <= 1'b0;
            state   <= S_IDLE;
          end else if (cnt == '0) begin
            state <= S_SAMPLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        S_SAMPLE: begin
          if (cap.abort) begin
            sel_q   <= '0;
            shift_q <= '0;
            busy_q  <= 1'b0;
            state   <= S_IDLE;
          end else begin
            shift_q <= {shift_q[NUM_INPUTS-2:0], f_in};
            if (sel_q == SEL_LAST) begin
              data_q <= {shift_q[NUM_INPUTS-2:0], f_in};
              busy_q <= 1'b0;
              done_q <= 1'b1;
              state  <= S_DONE;
            end else begin
              sel_q <= sel_q + 3'd1;
              cnt   <= CNT_RELOAD;
              state <= FIRST_STEP;
            end
          end
        end

        S_DONE: begin
          // sel holds SEL_LAST during the done cycle and returns to 0 here.
          sel_q <= '0;
          state <= S_IDLE;
        end

        default: begin
          sel_q  <= '0;
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  assign sel          = sel_q;
  assign cap.busy     = busy_q;
  assign cap.done     = done_q;
  assign cap.data_out = data_q;

endmodule

// File: tb/tb_mux_scan_capture.sv
module tb_mux_scan_capture;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [4:0] mux_in = 5'b00000;   // mux_in[4] = a ... mux_in[0] = e

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Instance 0: SETTLE_CYCLES = 1, instance 1: SETTLE_CYCLES = 0
  mux_scan_capture_if cap1 ();
  mux_scan_capture_if cap0 ();
  logic [2:0] sel1, sel0;
  logic       f1, f0;

  assign cap1.start = start;
  assign cap1.abort = abort;
  assign cap0.start = start;
  assign cap0.abort = abort;

  mux_scan_capture #(.SETTLE_CYCLES(1), .CNT_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .cap(cap1.slave), .f_in(f1), .sel(sel1));
  mux_scan_capture #(.SETTLE_CYCLES(0), .CNT_W(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .cap(cap0.slave), .f_in(f0), .sel(sel0));

  five_to_one_mux_using_case mux1 (
    .a(mux_in[4]), .b(mux_in[3]), .c(mux_in[2]), .d(mux_in[1]), .e(mux_in[0]),
    .s(sel1), .f(f1));
  five_to_one_mux_using_case mux0 (
    .a(mux_in[4]), .b(mux_in[3]), .c(mux_in[2]), .d(mux_in[1]), .e(mux_in[0]),
    .s(sel0), .f(f0));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Model: a capture is a timeline t = 0 .. 5*L-1 (L = settle + 1 cycles per
  // input) of busy cycles, then t = 5*L is the done cycle; t = -1 is idle.
  int         m_t    [2] = '{-1, -1};
  logic [4:0] m_acc  [2] = '{5'b0, 5'b0};
  logic [4:0] m_data [2] = '{5'b0, 5'b0};

  function automatic int per_step(int k);
    return (k == 0) ? 2 : 1;
  endfunction

  task automatic model_step(int k);
    int L, N;
    L = per_step(k);
    N = 5 * L;
    if (m_t[k] >= 0 && m_t[k] < N) begin
      if (abort) begin
        m_t[k] = -1;
      end else begin
        if (m_t[k] % L == L - 1)
          m_acc[k] = {m_acc[k][3:0], mux_in[4 - m_t[k] / L]};
        m_t[k] = m_t[k] + 1;
        if (m_t[k] == N) m_data[k] = m_acc[k];
      end
    end else if (m_t[k] == N) begin
      m_t[k] = -1;
    end else if (start && !abort) begin
      m_t[k]   = 0;
      m_acc[k] = 5'b0;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_t[k] = -1; m_acc[k] = 5'b0; m_data[k] = 5'b0;
      end
    end else begin
      model_step(0);
      model_step(1);
    end
  end

  function automatic logic [2:0] exp_sel(int k);
    int L;
    L = per_step(k);
    if (m_t[k] >= 0 && m_t[k] < 5 * L) return 3'(m_t[k] / L);
    if (m_t[k] == 5 * L) return 3'd4;
    return 3'd0;
  endfunction

  function automatic logic exp_busy(int k);
    return (m_t[k] >= 0 && m_t[k] < 5 * per_step(k));
  endfunction

  function automatic logic exp_done(int k);
    return (m_t[k] == 5 * per_step(k));
  endfunction

  always @(negedge clk) begin
    check("sel_s1",  sel1,          exp_sel(0));
    check("busy_s1", cap1.busy,     exp_busy(0));
    check("done_s1", cap1.done,     exp_done(0));
    check("data_s1", cap1.data_out, m_data[0]);
    check("sel_s0",  sel0,          exp_sel(1));
    check("busy_s0", cap0.busy,     exp_busy(1));
    check("done_s0", cap0.done,     exp_done(1));
    check("data_s0", cap0.data_out, m_data[1]);
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int         first_done1, first_done0, second_done1, n_done1, n_busy1;
  logic [29:0] sel_seq;

  initial begin
    // Reset, then idle
    step(3);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      check("idle_outputs", {sel1, cap1.busy, cap1.done, cap1.data_out}, 10'b0);
    end

    // Zero settle: inputs 0,1,0,0,1
    mux_in = 5'b01001;
    start = 1'b1;
    step(1);
    start = 1'b0;
    first_done0 = -1;
    for (int i = 0; i <= 12; i++) begin
      if (i > 0) step(1);
      if (cap0.done && first_done0 < 0) first_done0 = i;
    end
    check("s0_done_latency", 32'(first_done0), 32'd5);
    check("s0_data", cap0.data_out, 5'b01001);
    step(2);

    // Single capture, settle 1: inputs 1,0,1,1,0
    mux_in = 5'b10110;
    start = 1'b1;
    step(1);
    start = 1'b0;
    first_done1 = -1;
    n_busy1 = 0;
    sel_seq = '0;
    for (int i = 0; i <= 12; i++) begin
      if (i > 0) step(1);
      if (i < 10) sel_seq = {sel_seq[26:0], sel1};
      if (cap1.busy) n_busy1++;
      if (cap1.done && first_done1 < 0) first_done1 = i;
    end
    check("s1_sel_sequence", sel_seq, 30'o0011223344);
    check("s1_busy_cycles", 32'(n_busy1), 32'd10);
    check("s1_done_latency", 32'(first_done1), 32'd10);
    check("s1_data", cap1.data_out, 5'b10110);
    step(2);

    // Abort at the third SAMPLE (t = 5)
    mux_in = 5'b00000;
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(5);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    check("abort_busy", cap1.busy, 1'b0);
    check("abort_sel", sel1, 3'd0);
    n_done1 = 0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      if (cap1.done) n_done1++;
    end
    check("abort_no_done", 32'(n_done1), 32'd0);
    check("abort_data_held", cap1.data_out, 5'b10110);

    // A fresh capture after the abort completes normally
    mux_in = 5'b11010;
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(12);
    check("post_abort_data", cap1.data_out, 5'b11010);

    // Level-high start: back-to-back captures every 12 cycles
    mux_in = 5'b11111;
    start = 1'b1;
    step(1);
    n_done1 = 0;
    first_done1 = -1;
    second_done1 = -1;
    for (int i = 1; i <= 36; i++) begin
      step(1);
      if (cap1.done) begin
        n_done1++;
        if (first_done1 < 0) first_done1 = i;
        else if (second_done1 < 0) second_done1 = i;
      end
    end
    start = 1'b0;
    check("level_done_count", 32'(n_done1), 32'd3);
    check("level_first_done", 32'(first_done1), 32'd10);
    check("level_period", 32'(second_done1 - first_done1), 32'd12);
    check("level_data", cap1.data_out, 5'b11111);
    step(15);

    // Asynchronous reset during a capture
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(4);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_sel", sel1, 3'd0);
    check("async_rst_busy", cap1.busy, 1'b0);
    check("async_rst_data", cap1.data_out, 5'b00000);
    check("async_rst_data_s0", cap0.data_out, 5'b00000);
    step(2);
    rst_n = 1'b1;
    n_done1 = 0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      if (cap1.done) n_done1++;
    end
    check("async_rst_no_done", 32'(n_done1), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_scan_capture.md
Name: mux_scan_capture

Overview:
- Upstream controller for the 5:1 single-bit select mux: drives its 3-bit select line and consumes its output bit.
- On a start request, steps select through 0..4, waits a programmable settle time at each step, samples the mux output, and assembles the five samples into one 5-bit word.
- Publishes the word with a one-cycle done pulse.
- Lets a single mux serve as a serial-to-parallel gather point for five slow status bits.

Parameters:
- SETTLE_CYCLES, 1, cycles to wait after each select change before sampling f_in; legal range 0..15.
- CNT_W, 4, settle counter width; must satisfy 2**CNT_W > SETTLE_CYCLES.

Ports:
- clk  input  1  single clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request one capture; sampled only in IDLE
- abort  input  1  synchronous cancel of an in-progress capture
- f_in  input  1  mux output bit
- sel  output  3  mux select line; always within 0..4
- busy  output  1  high in SETTLE and SAMPLE
- done  output  1  one-cycle pulse; data_out valid from this cycle on
- data_out  output  5  captured word; bit 4 = select 0 input (a, MSB) ... bit 0 = select 4 input (e)

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, sel=0, busy=0, done=0, data_out=5'b0, shift register=0, counter=0.
  - Takes effect immediately, including mid-capture; partial data is discarded.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - sel=0.
  - start=1 at an edge -> sel<=0, cnt<=SETTLE_CYCLES-1.
  - Next state is SETTLE, or SAMPLE directly if SETTLE_CYCLES=0.
- SETTLE:
  - cnt decrements each cycle.
  - When cnt==0 at an edge -> SAMPLE.
  - Stays exactly SETTLE_CYCLES cycles per step.
- SAMPLE (one cycle):
  - At the edge, shift register <= {shift[3:0], f_in}.
  - If sel==4 -> DONE; data_out <= {shift[3:0], f_in}.
  - Otherwise sel<=sel+1, reload cnt, and go to SETTLE (or SAMPLE again if SETTLE_CYCLES=0).
- DONE (one cycle):
  - done=1, busy=0, sel<=0.
  - Next state is IDLE unconditionally.
  - start during DONE is ignored; start must be re-asserted in IDLE.
- Latency:
  - Start accepted at edge k; done is high during the cycle after edge k+5*(SETTLE_CYCLES+1).
  - SETTLE_CYCLES=1: done is high 10 cycles after the accepting edge.
- data_out:
  - Updates only on entry to DONE.
  - Holds its value through IDLE, the next capture, and any abort.
- sel:
  - Changes only at edges, never glitches combinationally (registered).
  - Values 5..7 are unreachable and must never be driven.
- start:
  - Ignored while busy or in DONE; no queuing.
  - A level-high start produces back-to-back captures with one IDLE cycle between DONE and the next SETTLE.
- abort:
  - abort=1 at an edge in SETTLE or SAMPLE -> IDLE, sel<=0, no done, data_out unchanged, shift register cleared.
  - abort has priority over sampling in the same cycle.
  - abort in IDLE or DONE has no effect; DONE still pulses.
  - abort together with start in IDLE: abort wins, capture not started.
- f_in is sampled only in SAMPLE; its value in all other states is don't-care.
- All outputs are registered.

Decomposition:
- Shared include file holds:
  - FSM state encodings (2-bit localparams S_IDLE, S_SETTLE, S_SAMPLE, S_DONE).
  - SEL_LAST=3'd4.
  - NUM_INPUTS=5.
- No sub-module is required; the settle counter stays inline.
- The bench instantiates this block together with five_to_one_mux_using_case, wiring sel->s and f->f_in.

Test Plan:
- Reset then idle: rst_n low 3 cycles, release, no start -> sel=0, busy=0, done=0, data_out=5'b00000 for 20 cycles.
- Single capture, SETTLE_CYCLES=1: mux inputs a..e=1,0,1,1,0, start pulse 1 cycle -> busy high 10 cycles, sel sequence 0,0,1,1,2,2,3,3,4,4, done pulse, data_out=5'b10110.
- SETTLE_CYCLES=0 with inputs a..e=0,1,0,0,1 -> sel advances every cycle, done 5 cycles after start, data_out=5'b01001.
- Abort mid-capture: previous data_out=5'b10110, start, abort at third SAMPLE -> IDLE next cycle, sel=0, no done pulse, data_out stays 5'b10110; a new start then completes normally.
- Start held high continuously with inputs 1,1,1,1,1 -> repeated done pulses every 12 cycles (SETTLE_CYCLES=1), data_out=5'b11111; start pulses while busy produce no extra captures.
- Async reset at cycle 4 of a capture -> outputs clear immediately (before the next clk edge), no done, data_out=0.
